// File: rtl/mr_scoreboard.sv
// Decode-stage register file with a per-register write-pending scoreboard.
// It tracks in-flight instructions and the outstanding jump, forwards the
// writeback value to same-cycle reads, and sets a sticky protocol-error flag.
module mr_scoreboard #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned NREGS        = 32,
   parameter int unsigned PEND_BITS    = 2,
   parameter int unsigned RD_PORTS     = 2,
   parameter int unsigned BYPASS       = 1,
   parameter int unsigned MAX_INFLIGHT = 4,
   localparam int unsigned REGSEL_W    = $clog2(NREGS),
   localparam int unsigned IF_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [RD_PORTS*REGSEL_W-1:0] rd_sel,
   input  logic [RD_PORTS-1:0]          rd_used,
   output logic [RD_PORTS*XLEN-1:0]     rd_data,
   output logic [RD_PORTS-1:0]          rd_hazard,
   output logic                         hazard,
   input  logic                         iss_fire,
   input  logic                         iss_uses_dst,
   input  logic [REGSEL_W-1:0]          iss_dst,
   input  logic                         iss_is_br,
   input  logic                         wb_valid,
   input  logic [REGSEL_W-1:0]          wb_reg,
   input  logic [XLEN-1:0]              wb_val,
   input  logic                         jmp_done,
   output logic [IF_W-1:0]              inflight,
   output logic                         jmp_pending,
   output logic                         err
);

   localparam logic BYP_EN = (BYPASS != 0);

   logic [XLEN-1:0]      regs [NREGS];
   logic [PEND_BITS-1:0] pend [NREGS];

   logic [REGSEL_W-1:0]  sel  [RD_PORTS];
   logic [RD_PORTS-1:0]  byp_hit;
   logic                 dst_inc;
   logic                 wb_dec;
   logic                 same_reg;
   logic                 jmp_stall;
   logic                 full_stall;
   logic                 dst_stall;
   logic                 err_set;

   // Operand read, bypass detection and per-port hazard.
   always_comb begin
      rd_data   = '0;
      rd_hazard = '0;
      byp_hit   = '0;
      for (int unsigned i = 0; i < RD_PORTS; i++) begin
         sel[i]     = rd_sel[i*REGSEL_W +: REGSEL_W];
         byp_hit[i] = BYP_EN && wb_valid && (wb_reg == sel[i]) && (sel[i] != '0)
                      && (pend[sel[i]] == PEND_BITS'(1));
         rd_hazard[i] = rd_used[i] && (sel[i] != '0) && (pend[sel[i]] != '0) && !byp_hit[i];
         if (sel[i] == '0)
            rd_data[i*XLEN +: XLEN] = '0;
         else if (byp_hit[i])
            rd_data[i*XLEN +: XLEN] = wb_val;
         else
            rd_data[i*XLEN +: XLEN] = regs[sel[i]];
      end
   end

   // Issue stall causes and protocol-error detection.
   always_comb begin
      dst_inc    = iss_fire && iss_uses_dst && (iss_dst != '0);
      wb_dec     = wb_valid && (wb_reg != '0);
      same_reg   = dst_inc && wb_dec && (iss_dst == wb_reg);
      jmp_stall  = jmp_pending && !(BYP_EN && jmp_done);
      full_stall = (inflight == IF_W'(MAX_INFLIGHT)) && !(BYP_EN && wb_valid);
      dst_stall  = iss_uses_dst && (iss_dst != '0) && (pend[iss_dst] == '1)
                   && !(wb_valid && (wb_reg == iss_dst));
      hazard     = (|rd_hazard) || jmp_stall || full_stall || dst_stall;
      err_set    = (iss_fire && hazard)
                   || (wb_dec && (pend[wb_reg] == '0) && !same_reg)
                   || (jmp_done && !jmp_pending)
                   || (iss_fire && iss_is_br && jmp_pending && !jmp_done)
                   || (wb_valid && !iss_fire && (inflight == '0))
                   || (iss_fire && !wb_valid && (inflight == IF_W'(MAX_INFLIGHT)));
   end

   // Register file and saturating pending-write counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
            pend[r] <= '0;
         end
      end else begin
         if (wb_dec)
            regs[wb_reg] <= wb_val;
         for (int unsigned r = 1; r < NREGS; r++) begin
            if (dst_inc && (iss_dst == REGSEL_W'(r)) && !same_reg && (pend[r] != '1))
               pend[r] <= pend[r] + PEND_BITS'(1);
            else if (wb_dec && (wb_reg == REGSEL_W'(r)) && !same_reg && (pend[r] != '0))
               pend[r] <= pend[r] - PEND_BITS'(1);
         end
      end
   end

   // In-flight count, outstanding jump and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight    <= '0;
         jmp_pending <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (iss_fire && !wb_valid && (inflight != IF_W'(MAX_INFLIGHT)))
            inflight <= inflight + IF_W'(1);
         else if (!iss_fire && wb_valid && (inflight != '0))
            inflight <= inflight - IF_W'(1);
         if (iss_fire && iss_is_br)
            jmp_pending <= 1'b1;
         else if (jmp_done)
            jmp_pending <= 1'b0;
         if (err_set)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mr_scoreboard.sv
// Bench for mr_scoreboard: directed scenarios followed by constrained-random
// traffic, all compared against a behavioural model of registers and counts.
module tb_mr_scoreboard;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned RSW   = 5;
   localparam int unsigned NP    = 2;
   localparam int unsigned IFW   = 3;
   localparam int          MAXI  = 4;
   localparam int          PMAX  = 3;
   localparam bit          BYP   = 1'b1;

   logic                clk = 1'b0;
   logic                rst;
   logic [NP*RSW-1:0]   rd_sel;
   logic [NP-1:0]       rd_used;
   logic [NP*XLEN-1:0]  rd_data;
   logic [NP-1:0]       rd_hazard;
   logic                hazard;
   logic                iss_fire, iss_uses_dst, iss_is_br;
   logic [RSW-1:0]      iss_dst;
   logic                wb_valid;
   logic [RSW-1:0]      wb_reg;
   logic [XLEN-1:0]     wb_val;
   logic                jmp_done;
   logic [IFW-1:0]      inflight;
   logic                jmp_pending;
   logic                err;

   int checks = 0;
   int failures = 0;

   // model state
   logic [XLEN-1:0] m_rf [NREGS];
   int              m_pend [NREGS];
   int              m_inflight;
   bit              m_jmp;
   bit              m_err;
   int              q[$];

   mr_scoreboard dut (
      .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_used(rd_used), .rd_data(rd_data),
      .rd_hazard(rd_hazard), .hazard(hazard), .iss_fire(iss_fire),
      .iss_uses_dst(iss_uses_dst), .iss_dst(iss_dst), .iss_is_br(iss_is_br),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val), .jmp_done(jmp_done),
      .inflight(inflight), .jmp_pending(jmp_pending), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int psel(input int p);
      return int'(rd_sel[p*RSW +: RSW]);
   endfunction

   function automatic bit exp_byp(input int p);
      int s = psel(p);
      return BYP && wb_valid && int'(wb_reg) == s && s != 0 && m_pend[s] == 1;
   endfunction

   function automatic logic [31:0] exp_rd(input int p);
      int s = psel(p);
      if (s == 0) return 32'h0;
      if (exp_byp(p)) return wb_val;
      return m_rf[s];
   endfunction

   function automatic bit exp_rdhz(input int p);
      int s = psel(p);
      return rd_used[p] && s != 0 && m_pend[s] != 0 && !exp_byp(p);
   endfunction

   function automatic bit exp_hazard();
      bit h = 1'b0;
      for (int p = 0; p < NP; p++) if (exp_rdhz(p)) h = 1'b1;
      if (m_jmp && !(BYP && jmp_done)) h = 1'b1;
      if (m_inflight == MAXI && !(BYP && wb_valid)) h = 1'b1;
      if (iss_uses_dst && iss_dst != 0 && m_pend[iss_dst] == PMAX
          && !(wb_valid && wb_reg == iss_dst)) h = 1'b1;
      return h;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) begin
         m_rf[r] = '0;
         m_pend[r] = 0;
      end
      m_inflight = 0;
      m_jmp = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic model_update();
      bit e = 1'b0;
      bit inc, dec;
      int ni;
      if (rst) begin
         model_reset();
         return;
      end
      inc = iss_fire && iss_uses_dst && iss_dst != 0;
      dec = wb_valid && wb_reg != 0;
      if (iss_fire && exp_hazard()) e = 1'b1;
      if (dec && m_pend[wb_reg] == 0 && !(inc && iss_dst == wb_reg)) e = 1'b1;
      if (jmp_done && !m_jmp) e = 1'b1;
      if (iss_fire && iss_is_br && m_jmp && !jmp_done) e = 1'b1;
      ni = m_inflight + int'(iss_fire) - int'(wb_valid);
      if (ni < 0) begin e = 1'b1; ni = 0; end
      if (ni > MAXI) begin e = 1'b1; ni = MAXI; end
      m_inflight = ni;
      if (!(inc && dec && iss_dst == wb_reg)) begin
         if (inc && m_pend[iss_dst] < PMAX) m_pend[iss_dst]++;
         if (dec && m_pend[wb_reg] > 0) m_pend[wb_reg]--;
      end
      if (dec) m_rf[wb_reg] = wb_val;
      if (iss_fire && iss_is_br) m_jmp = 1'b1;
      else if (jmp_done) m_jmp = 1'b0;
      if (e) m_err = 1'b1;
   endtask

   task automatic check_all();
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("rd_data%0d", p), rd_data[p*XLEN +: XLEN], exp_rd(p));
         chk($sformatf("rd_hazard%0d", p), 32'(rd_hazard[p]), 32'(exp_rdhz(p)));
      end
      chk("hazard", 32'(hazard), 32'(exp_hazard()));
      chk("inflight", 32'(inflight), 32'(m_inflight));
      chk("jmp_pending", 32'(jmp_pending), 32'(m_jmp));
      chk("err", 32'(err), 32'(m_err));
   endtask

   // Inputs are set at posedge+1; outputs checked at posedge+3; model follows the edge.
   task automatic step();
      #2;
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; rd_sel = '0; rd_used = '0;
      iss_fire = 1'b0; iss_uses_dst = 1'b0; iss_dst = '0; iss_is_br = 1'b0;
      wb_valid = 1'b0; wb_reg = '0; wb_val = '0; jmp_done = 1'b0;
   endtask

   task automatic rd(input int p, input int s, input bit used);
      rd_sel[p*RSW +: RSW] = RSW'(s);
      rd_used[p] = used;
   endtask

   task automatic issue(input int dst, input bit br);
      idle();
      iss_fire = 1'b1; iss_uses_dst = (dst != 0); iss_dst = RSW'(dst); iss_is_br = br;
      step();
   endtask

   task automatic wb(input int r, input logic [31:0] v);
      idle();
      wb_valid = 1'b1; wb_reg = RSW'(r); wb_val = v;
      step();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();

      // reset state
      idle(); rd(0, 0, 1); rd(1, 5, 1);
      #1;
      chk("rst_hazard", 32'(hazard), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      step();

      // single pending write, then same-cycle bypass
      issue(3, 0);
      idle(); rd(0, 3, 1);
      #1; chk("x3_stall", 32'(rd_hazard[0]), 32'h1);
      step();
      idle(); rd(0, 3, 1); wb_valid = 1'b1; wb_reg = 5'd3; wb_val = 32'hDEAD;
      #1;
      chk("byp_data", rd_data[31:0], 32'hDEAD);
      chk("byp_hazard", 32'(hazard), 32'h0);
      step();

      // two writes pending to x3
      issue(3, 0);
      issue(3, 0);
      idle(); rd(1, 3, 1); wb_valid = 1'b1; wb_reg = 5'd3; wb_val = 32'h1111;
      #1; chk("pend2_first_wb", 32'(hazard), 32'h1);
      step();
      idle(); rd(1, 3, 1); wb_valid = 1'b1; wb_reg = 5'd3; wb_val = 32'h2222;
      #1; chk("pend2_second_wb", 32'(hazard), 32'h0);
      step();

      // saturated pending counter blocks a further writer
      issue(7, 0); issue(7, 0); issue(7, 0);
      idle(); iss_uses_dst = 1'b1; iss_dst = 5'd7;
      #1; chk("pend_full", 32'(hazard), 32'h1);
      step();
      wb(7, 32'h7); wb(7, 32'h77); wb(7, 32'h777);

      // in-flight limit
      issue(0, 0); issue(0, 0); issue(0, 0); issue(0, 0);
      idle();
      #1;
      chk("if_full_cnt", 32'(inflight), 32'd4);
      chk("if_full_haz", 32'(hazard), 32'h1);
      step();
      wb(0, 32'h0);
      chk("if_after_wb", 32'(inflight), 32'd3);
      wb(0, 32'h0); wb(0, 32'h0); wb(0, 32'h0);

      // branch outstanding
      issue(0, 1);
      idle();
      #1;
      chk("jmp_set", 32'(jmp_pending), 32'h1);
      chk("jmp_haz", 32'(hazard), 32'h1);
      step();
      idle(); jmp_done = 1'b1; step();
      wb(0, 32'h0);
      chk("jmp_clr", 32'(jmp_pending), 32'h0);
      chk("no_err_yet", 32'(err), 32'h0);

      // stray writeback
      wb(9, 32'h99);
      idle(); rd(0, 9, 1);
      #1;
      chk("stray_err", 32'(err), 32'h1);
      chk("stray_pend", 32'(rd_hazard[0]), 32'h0);
      step();
      idle(); step(); step();
      chk("err_sticky", 32'(err), 32'h1);

      // same-cycle issue and writeback to x4
      do_reset();
      chk("err_cleared", 32'(err), 32'h0);
      issue(4, 0);
      idle(); iss_fire = 1'b1; iss_uses_dst = 1'b1; iss_dst = 5'd4;
      wb_valid = 1'b1; wb_reg = 5'd4; wb_val = 32'h1234;
      step();
      idle(); rd(0, 4, 1);
      #1;
      chk("x4_pend", 32'(rd_hazard[0]), 32'h1);
      chk("x4_data", rd_data[31:0], 32'h1234);
      step();
      wb(4, 32'h4444);

      // constrained-random traffic
      do_reset();
      q.delete();
      for (int c = 0; c < 2000; c++) begin
         idle();
         if (c == 1000) begin
            rst = 1'b1;
            q.delete();
            step();
            continue;
         end
         rd(0, $urandom_range(0, 7), $urandom_range(0, 1) == 1);
         rd(1, $urandom_range(0, 31), $urandom_range(0, 1) == 1);
         if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            wb_valid = 1'b1;
            wb_reg = RSW'(q.pop_front());
            wb_val = $urandom;
         end
         if (m_jmp && $urandom_range(0, 2) == 0) jmp_done = 1'b1;
         iss_uses_dst = $urandom_range(0, 3) != 0;
         iss_dst = RSW'($urandom_range(0, 7));
         iss_is_br = $urandom_range(0, 4) == 0;
         if ($urandom_range(0, 99) == 0) begin
            iss_fire = 1'b1;
            if ($urandom_range(0, 1) == 1) jmp_done = 1'b1;
         end else begin
            iss_fire = !exp_hazard() && $urandom_range(0, 4) < 3;
         end
         if (iss_fire) q.push_back((iss_uses_dst && iss_dst != 0) ? int'(iss_dst) : 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
